// File: rtl/ecg_window_loader.sv
// Sliding-window loader: shifts ECG samples into a 15-deep parallel window and
// hands a complete window downstream, keeping 15-STRIDE samples of overlap between windows.
module ecg_window_loader #(
  parameter int STRIDE = 15,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      A0x,
  output logic [31:0]      A1x,
  output logic [31:0]      A2x,
  output logic [31:0]      A3x,
  output logic [31:0]      A4x,
  output logic [31:0]      A5x,
  output logic [31:0]      A6x,
  output logic [31:0]      A7x,
  output logic [31:0]      A8x,
  output logic [31:0]      A9x,
  output logic [31:0]      A10x,
  output logic [31:0]      A11x,
  output logic [31:0]      A12x,
  output logic [31:0]      A13x,
  output logic [31:0]      A14x,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [3:0]       fill_cnt,
  output logic [CNT_W-1:0] win_cnt
);

  localparam int             DATA_W = 32;
  localparam int             DEPTH  = 15;
  localparam logic [3:0]     REFILL = 4'(DEPTH - STRIDE);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] win [DEPTH];
  logic              accept;
  logic              consume;

  // Handshakes depend only on the state register, so no input reaches them combinationally.
  assign in_ready  = (state == FILL);
  assign win_valid = (state == FULL);
  assign accept    = in_valid & in_ready;
  assign consume   = win_valid & win_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      fill_cnt <= 4'd0;
      win_cnt  <= '0;
    end else if (flush) begin
      state    <= FILL;
      fill_cnt <= 4'd0;
    end else if (consume) begin
      state    <= FILL;
      fill_cnt <= REFILL;
      win_cnt  <= win_cnt + CNT_ONE;
    end else if (accept) begin
      fill_cnt <= fill_cnt + 4'd1;
      if (fill_cnt == 4'd14) begin
        state <= FULL;
      end
    end
  end

  // Data is left untouched by consume; the older samples drop out of A0x on later accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (accept && !flush) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        win[i] <= win[i+1];
      end
      win[DEPTH-1] <= in_data;
    end
  end

  assign A0x  = win[0];
  assign A1x  = win[1];
  assign A2x  = win[2];
  assign A3x  = win[3];
  assign A4x  = win[4];
  assign A5x  = win[5];
  assign A6x  = win[6];
  assign A7x  = win[7];
  assign A8x  = win[8];
  assign A9x  = win[9];
  assign A10x = win[10];
  assign A11x = win[11];
  assign A12x = win[12];
  assign A13x = win[13];
  assign A14x = win[14];

endmodule

// File: tb/tb_ecg_window_loader.sv
// Bench for ecg_window_loader: two instances (STRIDE=15/CNT_W=16 and STRIDE=5/CNT_W=2)
// share stimulus and are checked every cycle against a window/queue model.
module tb_ecg_window_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        win_ready;
  logic [31:0] in_data;

  wire         rdy [2];
  wire         wv  [2];
  wire [3:0]   fc  [2];
  wire [31:0]  a   [2][15];
  wire [15:0]  wc0;
  wire [1:0]   wc1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  ecg_window_loader #(.STRIDE(15), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]),
    .A0x(a[0][0]),   .A1x(a[0][1]),   .A2x(a[0][2]),   .A3x(a[0][3]),   .A4x(a[0][4]),
    .A5x(a[0][5]),   .A6x(a[0][6]),   .A7x(a[0][7]),   .A8x(a[0][8]),   .A9x(a[0][9]),
    .A10x(a[0][10]), .A11x(a[0][11]), .A12x(a[0][12]), .A13x(a[0][13]), .A14x(a[0][14]),
    .win_valid(wv[0]), .win_ready(win_ready), .fill_cnt(fc[0]), .win_cnt(wc0)
  );

  ecg_window_loader #(.STRIDE(5), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]),
    .A0x(a[1][0]),   .A1x(a[1][1]),   .A2x(a[1][2]),   .A3x(a[1][3]),   .A4x(a[1][4]),
    .A5x(a[1][5]),   .A6x(a[1][6]),   .A7x(a[1][7]),   .A8x(a[1][8]),   .A9x(a[1][9]),
    .A10x(a[1][10]), .A11x(a[1][11]), .A12x(a[1][12]), .A13x(a[1][13]), .A14x(a[1][14]),
    .win_valid(wv[1]), .win_ready(win_ready), .fill_cnt(fc[1]), .win_cnt(wc1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: the window is the last 15 accepted samples (zero-padded), it is
  // complete exactly when 15 samples are held, and a consume keeps 15-STRIDE of them.
  logic [31:0] mwin [2][15];
  int          mfill [2];
  int          mwc   [2];
  int          mstr  [2] = '{15, 5};
  int          mmod  [2] = '{65536, 4};

  function automatic void mreset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 15; i++) mwin[k][i] = 32'h0;
      mfill[k] = 0;
      mwc[k]   = 0;
    end
  endfunction

  always @(negedge rst_n) mreset();

  always @(posedge clk) begin
    if (!rst_n) begin
      mreset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          mfill[k] = 0;
        end else if (mfill[k] == 15) begin
          if (win_ready) begin
            mfill[k] = 15 - mstr[k];
            mwc[k]   = (mwc[k] + 1) % mmod[k];
          end
        end else if (in_valid) begin
          for (int i = 0; i < 14; i++) mwin[k][i] = mwin[k][i+1];
          mwin[k][14] = in_data;
          mfill[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d.in_ready", k), {31'b0, rdy[k]}, {31'b0, mfill[k] != 15});
        chk($sformatf("d%0d.win_valid", k), {31'b0, wv[k]}, {31'b0, mfill[k] == 15});
        chk($sformatf("d%0d.fill_cnt", k), {28'b0, fc[k]}, 32'(mfill[k]));
        chk($sformatf("d%0d.win_cnt", k), (k == 0) ? {16'b0, wc0} : {30'b0, wc1}, 32'(mwc[k]));
        for (int i = 0; i < 15; i++)
          chk($sformatf("d%0d.A%0dx", k, i), a[k][i], mwin[k][i]);
      end
    end
  end

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic consume_pulse();
    win_ready = 1'b1;
    @(posedge clk); #1;
    win_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  int seq [5] = '{1, 2, 3, 0, 1};

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; win_ready = 1'b0; in_data = 32'h0;
    mreset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", {31'b0, rdy[0]}, 32'd1);
    chk("rst.win_valid", {31'b0, wv[0]}, 32'd0);
    chk("rst.fill_cnt", {28'b0, fc[0]}, 32'd0);
    chk("rst.A14x", a[0][14], 32'h0);
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // 15 consecutive float samples form the first window
    for (int i = 0; i < 15; i++) begin
      send(32'h3F800000 + 32'(i));
      if (i == 13) chk("fill14.win_valid", {31'b0, wv[0]}, 32'd0);
    end
    chk("win1.win_valid", {31'b0, wv[0]}, 32'd1);
    chk("win1.A0x", a[0][0], 32'h3F800000);
    chk("win1.A14x", a[0][14], 32'h3F80000E);
    chk("win1.fill_cnt", {28'b0, fc[0]}, 32'd15);

    // FULL ignores input while win_ready is low
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = $urandom;
      @(posedge clk); #1;
      chk("hold.in_ready", {31'b0, rdy[0]}, 32'd0);
      chk("hold.A14x", a[0][14], 32'h3F80000E);
    end
    in_valid = 1'b0;
    consume_pulse();
    chk("cons.win_cnt", {16'b0, wc0}, 32'd1);
    chk("cons.fill_cnt", {28'b0, fc[0]}, 32'd0);
    chk("cons.win_valid", {31'b0, wv[0]}, 32'd0);
    chk("cons.d1_fill_cnt", {28'b0, fc[1]}, 32'd10);

    // Overlapping windows with STRIDE=5
    do_reset();
    for (int i = 0; i < 15; i++) send(32'(i));
    consume_pulse();
    for (int i = 15; i < 19; i++) send(32'(i));
    chk("s5.early_win_valid", {31'b0, wv[1]}, 32'd0);
    send(32'd19);
    chk("s5.win_valid", {31'b0, wv[1]}, 32'd1);
    chk("s5.A0x", a[1][0], 32'd5);
    chk("s5.A14x", a[1][14], 32'd19);

    // Flush against a simultaneous accept
    do_reset();
    for (int i = 0; i < 9; i++) send(32'd100 + 32'(i));
    chk("flush.pre_fill", {28'b0, fc[0]}, 32'd9);
    flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush.fill_cnt", {28'b0, fc[0]}, 32'd0);
    chk("flush.A14x", a[0][14], 32'd108);
    chk("flush.A6x", a[0][6], 32'd100);

    // Asynchronous reset while FULL
    do_reset();
    for (int i = 0; i < 15; i++) send($urandom);
    consume_pulse();
    for (int i = 0; i < 15; i++) send($urandom | 32'h1);
    chk("areset.pre_wv", {31'b0, wv[0]}, 32'd1);
    chk("areset.pre_wc", {16'b0, wc0}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("areset.win_valid", {31'b0, wv[0]}, 32'd0);
    chk("areset.A0x", a[0][0], 32'h0);
    chk("areset.A14x", a[0][14], 32'h0);
    chk("areset.win_cnt", {16'b0, wc0}, 32'd0);
    chk("areset.in_ready", {31'b0, rdy[0]}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2-bit window counter wraps
    for (int i = 0; i < 15; i++) send($urandom);
    for (int k = 0; k < 5; k++) begin
      consume_pulse();
      chk($sformatf("wrap.win_cnt%0d", k), {30'b0, wc1}, 32'(seq[k]));
      for (int j = 0; j < 5; j++) send($urandom);
    end

    // Randomised traffic including gaps, flushes and occasional resets
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      win_ready = ($urandom_range(0, 9) < 3);
      flush     = ($urandom_range(0, 63) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; win_ready = 1'b0; flush = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
